// File: rtl/ddr5_flt_pkg.sv
// Shared types and default constants for the DDR5 fault monitor.
package ddr5_flt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_REQ     = 2'd2,
    ST_LATCHED = 2'd3
  } fltState_t;

  localparam int DEF_MC_SIZE        = 4;
  localparam int DEF_FILT_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 2000;

endpackage

// File: rtl/ddr5_flt_monitor_if.sv
// Fault/handshake/log bundle between the DDR5 fault monitor (master) and its environment (slave).
interface ddr5_flt_monitor_if #(
  parameter int MC_SIZE = ddr5_flt_pkg::DEF_MC_SIZE
);
  localparam int IDX_W = (MC_SIZE > 1) ? $clog2(MC_SIZE) : 1;

  logic               iCpuPwrGd;
  logic               iSlpS5Id;
  logic [MC_SIZE-1:0] iDIMM_MEM_FLT;
  logic [MC_SIZE-1:0] iPWRGD_DRAMPWRGD_OK;
  logic               iFltAck;
  logic               oFltPwrDwnReq;
  logic               oFltValid;
  logic [MC_SIZE-1:0] oFltMask;
  logic [IDX_W-1:0]   oFirstFltIdx;
  logic               oAckTimeout;

  modport master (
    input  iCpuPwrGd, iSlpS5Id, iDIMM_MEM_FLT, iPWRGD_DRAMPWRGD_OK, iFltAck,
    output oFltPwrDwnReq, oFltValid, oFltMask, oFirstFltIdx, oAckTimeout
  );

  modport slave (
    output iCpuPwrGd, iSlpS5Id, iDIMM_MEM_FLT, iPWRGD_DRAMPWRGD_OK, iFltAck,
    input  oFltPwrDwnReq, oFltValid, oFltMask, oFirstFltIdx, oAckTimeout
  );

endinterface

// File: rtl/ddr5_flt_filter.sv
// Per-channel consecutive-sample fault filter with saturating counter and qualify pulse.
module ddr5_flt_filter
  import ddr5_flt_pkg::*;
#(
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClr,
  input  logic iFlt,
  output logic oQual
);
  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES);

  logic [CNT_W-1:0] cntReg;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cntReg <= '0;
    end else if (iClr || !iFlt) begin
      cntReg <= '0;
    end else if (cntReg != CNT_MAX) begin
      cntReg <= cntReg + CNT_W'(1);
    end
  end

  // Pulse is high during the cycle whose closing edge brings the count to FILT_CYCLES,
  // so the top can register the qualification on that very edge.
  assign oQual = !iClr && iFlt && (cntReg == CNT_MAX - CNT_W'(1));

endmodule

// File: rtl/ddr5_flt_monitor.sv
// DDR5 fault qualifier: arms on CPU/DRAM power good, filters per-MC faults, requests
// power-down with ack handshake and keeps a sticky fault log. Optional ack timeout: DDR5_FLT_ACK_TIMEOUT_EN.
module ddr5_flt_monitor
  import ddr5_flt_pkg::*;
#(
  parameter int MC_SIZE        = DEF_MC_SIZE,
  parameter int FILT_CYCLES    = DEF_FILT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic iClk,
  input logic iRst_n,
  ddr5_flt_monitor_if.master bus
);
  localparam int IDX_W = (MC_SIZE > 1) ? $clog2(MC_SIZE) : 1;

  fltState_t          stateReg;
  logic               reqReg;
  logic               validReg;
  logic [MC_SIZE-1:0] maskReg;
  logic [IDX_W-1:0]   idxReg;
  logic               toReg;

  logic [MC_SIZE-1:0] qual;
  logic [IDX_W-1:0]   firstIdx;
  logic               armOk;
  logic               timeoutHit;

  generate
    for (genvar gi = 0; gi < MC_SIZE; gi++) begin : gFilt
      ddr5_flt_filter #(
        .FILT_CYCLES(FILT_CYCLES)
      ) uFilt (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iClr  (stateReg == ST_IDLE),
        .iFlt  (bus.iDIMM_MEM_FLT[gi]),
        .oQual (qual[gi])
      );
    end
  endgenerate

  // Scan downward so the lowest set index is the one left standing.
  always_comb begin
    firstIdx = '0;
    for (int i = MC_SIZE - 1; i >= 0; i--) begin
      if (qual[i]) firstIdx = IDX_W'(i);
    end
  end

  assign armOk = bus.iCpuPwrGd && (&bus.iPWRGD_DRAMPWRGD_OK) && !bus.iSlpS5Id;

`ifdef DDR5_FLT_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] toCntReg;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      toCntReg <= '0;
    end else if (stateReg != ST_REQ) begin
      toCntReg <= '0;
    end else begin
      toCntReg <= toCntReg + TO_W'(1);
    end
  end

  assign timeoutHit = (toCntReg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateReg <= ST_IDLE;
      reqReg   <= 1'b0;
      validReg <= 1'b0;
      maskReg  <= '0;
      idxReg   <= '0;
      toReg    <= 1'b0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (armOk) stateReg <= ST_ARMED;
        end
        ST_ARMED: begin
          // A normal S5/power-good drop is not a fault and beats a same-edge qualification.
          if (!bus.iCpuPwrGd || bus.iSlpS5Id) begin
            stateReg <= ST_IDLE;
          end else if (|qual) begin
            stateReg <= ST_REQ;
            reqReg   <= 1'b1;
            validReg <= 1'b1;
            maskReg  <= qual;
            idxReg   <= firstIdx;
          end
        end
        ST_REQ: begin
          maskReg <= maskReg | qual;
          if (bus.iFltAck) begin
            stateReg <= ST_LATCHED;
            reqReg   <= 1'b0;
          end else if (timeoutHit) begin
            stateReg <= ST_LATCHED;
            reqReg   <= 1'b0;
            toReg    <= 1'b1;
          end
        end
        ST_LATCHED: begin
          if (bus.iSlpS5Id) begin
            stateReg <= ST_IDLE;
            validReg <= 1'b0;
            maskReg  <= '0;
            idxReg   <= '0;
            toReg    <= 1'b0;
          end else begin
            maskReg <= maskReg | qual;
          end
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  assign bus.oFltPwrDwnReq = reqReg;
  assign bus.oFltValid     = validReg;
  assign bus.oFltMask      = maskReg;
  assign bus.oFirstFltIdx  = idxReg;
  assign bus.oAckTimeout   = toReg;

endmodule

// File: tb/tb_ddr5_flt_monitor.sv
// Self-checking bench for ddr5_flt_monitor: directed scenarios plus randomized traffic
// against a run-length based behavioural model compared every cycle.
module tb_ddr5_flt_monitor;
  localparam int MC   = 4;
  localparam int FILT = 4;
  localparam int TO   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int nChecks = 0;
  int nBad    = 0;

  ddr5_flt_monitor_if #(.MC_SIZE(MC)) bus ();

  ddr5_flt_monitor #(
    .MC_SIZE       (MC),
    .FILT_CYCLES   (FILT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: 0 = disarmed, 1 = watching, 2 = requesting, 3 = logged/waiting for S5
  int       mMode = 0;
  int       run[MC];
  bit       mReq = 0, mValid = 0, mTo = 0;
  bit [3:0] mMask = 0;
  int       mIdx = 0;
  int       mWait = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowestBit(input bit [3:0] v);
    bit [3:0] iso;
    iso = v & (~v + 4'd1);
    return $clog2(iso);
  endfunction

  initial begin
    foreach (run[c]) run[c] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mMode = 0; mReq = 0; mValid = 0; mTo = 0; mMask = 0; mIdx = 0; mWait = 0;
        foreach (run[c]) run[c] = 0;
      end else begin
        bit       pg, s5, ack;
        bit [3:0] flt, ok, q;
        pg = bus.iCpuPwrGd; s5 = bus.iSlpS5Id; ack = bus.iFltAck;
        flt = bus.iDIMM_MEM_FLT; ok = bus.iPWRGD_DRAMPWRGD_OK;
        q = 0;
        for (int c = 0; c < MC; c++) begin
          if (mMode == 0) run[c] = 0;
          else begin
            run[c] = flt[c] ? run[c] + 1 : 0;
            if (run[c] == FILT) q[c] = 1;
          end
        end
        case (mMode)
          0: if (pg && ok == 4'hF && !s5) mMode = 1;
          1: begin
            if (!pg || s5) mMode = 0;
            else if (q != 0) begin
              mMode = 2; mReq = 1; mValid = 1; mMask = q; mIdx = lowestBit(q); mWait = 0;
            end
          end
          2: begin
            mMask |= q;
            if (ack) begin mMode = 3; mReq = 0; end
            else begin
              mWait++;
`ifdef DDR5_FLT_ACK_TIMEOUT_EN
              if (mWait == TO) begin mMode = 3; mReq = 0; mTo = 1; end
`endif
            end
          end
          default: begin
            if (s5) begin mMode = 0; mValid = 0; mMask = 0; mIdx = 0; mTo = 0; end
            else mMask |= q;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_req",   int'(bus.oFltPwrDwnReq), int'(mReq));
        chk("cyc_valid", int'(bus.oFltValid),     int'(mValid));
        chk("cyc_mask",  int'(bus.oFltMask),      int'(mMask));
        chk("cyc_idx",   int'(bus.oFirstFltIdx),  mIdx);
        chk("cyc_to",    int'(bus.oAckTimeout),   int'(mTo));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic s5Clear();
    bus.iSlpS5Id = 1; step(1); bus.iSlpS5Id = 0;
  endtask

  task automatic showTxn(input string nm);
    $display("txn %-10s req=%0b valid=%0b mask=%b idx=%0d to=%0b", nm, bus.oFltPwrDwnReq,
             bus.oFltValid, bus.oFltMask, bus.oFirstFltIdx, bus.oAckTimeout);
  endtask

  initial begin
    bus.iCpuPwrGd = 0; bus.iSlpS5Id = 0; bus.iDIMM_MEM_FLT = 0;
    bus.iPWRGD_DRAMPWRGD_OK = 0; bus.iFltAck = 0;
    step(3);
    rst_n = 1;
    chk("rst_req", int'(bus.oFltPwrDwnReq), 0);
    chk("rst_mask", int'(bus.oFltMask), 0);

    // Basic qualification on ch2 then ack
    bus.iCpuPwrGd = 1; bus.iPWRGD_DRAMPWRGD_OK = 4'hF;
    step(1);
    bus.iDIMM_MEM_FLT = 4'b0100;
    step(3);
    chk("basic_req_early", int'(bus.oFltPwrDwnReq), 0);
    step(1);
    showTxn("basic");
    chk("basic_req", int'(bus.oFltPwrDwnReq), 1);
    chk("basic_mask", int'(bus.oFltMask), 4);
    chk("basic_idx", int'(bus.oFirstFltIdx), 2);
    chk("basic_valid", int'(bus.oFltValid), 1);
    bus.iFltAck = 1; step(1); bus.iFltAck = 0;
    showTxn("ack");
    chk("ack_req", int'(bus.oFltPwrDwnReq), 0);
    chk("ack_mask", int'(bus.oFltMask), 4);
    bus.iDIMM_MEM_FLT = 0;
    s5Clear();
    chk("s5_valid", int'(bus.oFltValid), 0);

    // Glitch on ch0 never reaches four in a row
    step(1);
    bus.iDIMM_MEM_FLT = 4'b0001; step(3);
    bus.iDIMM_MEM_FLT = 0;       step(1);
    bus.iDIMM_MEM_FLT = 4'b0001; step(3);
    bus.iDIMM_MEM_FLT = 0;       step(1);
    showTxn("glitch");
    chk("glitch_req", int'(bus.oFltPwrDwnReq), 0);
    chk("glitch_valid", int'(bus.oFltValid), 0);

    // Simultaneous ch1+ch3, later ch0 while latched
    bus.iDIMM_MEM_FLT = 4'b1010; step(4);
    showTxn("simul");
    chk("simul_mask", int'(bus.oFltMask), 4'b1010);
    chk("simul_idx", int'(bus.oFirstFltIdx), 1);
    bus.iFltAck = 1; step(1); bus.iFltAck = 0;
    bus.iDIMM_MEM_FLT = 4'b1011; step(4);
    showTxn("late");
    chk("late_mask", int'(bus.oFltMask), 4'b1011);
    chk("late_idx", int'(bus.oFirstFltIdx), 1);
    chk("late_req", int'(bus.oFltPwrDwnReq), 0);
    bus.iDIMM_MEM_FLT = 0;
    s5Clear();
    chk("clr_mask", int'(bus.oFltMask), 0);
    chk("clr_idx", int'(bus.oFirstFltIdx), 0);

    // Disarm mid-count, re-arm restarts the count
    step(1);
    bus.iDIMM_MEM_FLT = 4'b0100; step(3);
    bus.iCpuPwrGd = 0; step(1);
    chk("disarm_req", int'(bus.oFltPwrDwnReq), 0);
    bus.iCpuPwrGd = 1; step(1);
    step(3);
    chk("rearm_req_early", int'(bus.oFltPwrDwnReq), 0);
    step(1);
    showTxn("rearm");
    chk("rearm_req", int'(bus.oFltPwrDwnReq), 1);
    chk("rearm_idx", int'(bus.oFirstFltIdx), 2);
    bus.iDIMM_MEM_FLT = 0;
    bus.iFltAck = 1; step(1); bus.iFltAck = 0;
    s5Clear();

    // Ack timeout behaviour
    step(1);
    bus.iDIMM_MEM_FLT = 4'b0001; step(4);
    bus.iDIMM_MEM_FLT = 0;
`ifdef DDR5_FLT_ACK_TIMEOUT_EN
    step(9);
    chk("to_before", int'(bus.oAckTimeout), 0);
    chk("to_req_before", int'(bus.oFltPwrDwnReq), 1);
    step(1);
    showTxn("timeout");
    chk("to_flag", int'(bus.oAckTimeout), 1);
    chk("to_req", int'(bus.oFltPwrDwnReq), 0);
    s5Clear();
    step(1);
    bus.iDIMM_MEM_FLT = 4'b0001; step(4);
    bus.iDIMM_MEM_FLT = 0;
    step(9);
    bus.iFltAck = 1; step(1); bus.iFltAck = 0;
    showTxn("to_ack");
    chk("to_ack_flag", int'(bus.oAckTimeout), 0);
    chk("to_ack_req", int'(bus.oFltPwrDwnReq), 0);
`else
    step(1000);
    showTxn("hold");
    chk("hold_req", int'(bus.oFltPwrDwnReq), 1);
    chk("hold_to", int'(bus.oAckTimeout), 0);
    bus.iFltAck = 1; step(1); bus.iFltAck = 0;
    chk("hold_ack_req", int'(bus.oFltPwrDwnReq), 0);
`endif
    s5Clear();

    // Asynchronous reset while requesting
    step(1);
    bus.iDIMM_MEM_FLT = 4'b0001; step(4);
    chk("pre_rst_req", int'(bus.oFltPwrDwnReq), 1);
    bus.iDIMM_MEM_FLT = 0;
    #1 rst_n = 0;
    #1;
    showTxn("async_rst");
    chk("arst_req", int'(bus.oFltPwrDwnReq), 0);
    chk("arst_valid", int'(bus.oFltValid), 0);
    chk("arst_mask", int'(bus.oFltMask), 0);
    step(2);
    rst_n = 1;
    step(1);
    chk("post_rst_valid", int'(bus.oFltValid), 0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      bus.iCpuPwrGd = ($urandom_range(0, 99) < 96);
      bus.iSlpS5Id  = ($urandom_range(0, 99) < 3);
      bus.iPWRGD_DRAMPWRGD_OK = ($urandom_range(0, 99) < 97) ? 4'hF : 4'($urandom_range(0, 15));
      for (int c = 0; c < MC; c++)
        if ($urandom_range(0, 99) < 18) bus.iDIMM_MEM_FLT[c] = ~bus.iDIMM_MEM_FLT[c];
      bus.iFltAck = ($urandom_range(0, 99) < 12);
      step(1);
      if (i % 500 == 0) showTxn("random");
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/ddr5_flt_monitor.md
# ddr5_flt_monitor

Per-platform DDR5 fault qualifier that sits directly downstream of the per-memory-controller DDR5 power-good/fail logic. It consumes the per-MC memory-fault and DRAMPWROK outputs and filters each fault over consecutive clocks. When a fault qualifies, it raises a power-down request toward the master sequencer with a request/acknowledge handshake. It keeps a sticky first-fault/fault-mask log for BMC/debug readout until the next S5 entry.

## Interface
- MC_SIZE, 4, number of memory controllers monitored (≥1)
- FILT_CYCLES, 4, consecutive asserted samples needed to qualify a fault (≥1)
- TIMEOUT_CYCLES, 2000, request-to-ack timeout in clocks (used only with DDR5_FLT_ACK_TIMEOUT_EN)
- IDX_W, derived, max(1, $clog2(MC_SIZE)), not user-set

Ports:
- iClk  in  1  system clock; all inputs are already synchronous to it
- iRst_n  in  1  asynchronous active-low reset
- iCpuPwrGd  in  1  CPU power good; arms the monitor
- iSlpS5Id  in  1  S5 indication; disarms the monitor and clears the log
- iDIMM_MEM_FLT  in  MC_SIZE  per-MC memory fault, active high
- iPWRGD_DRAMPWRGD_OK  in  MC_SIZE  per-MC DRAMPWROK; all must be high to arm
- iFltAck  in  1  sequencer acknowledge of the power-down request
- oFltPwrDwnReq  out  1  power-down request, level, held until ack
- oFltValid  out  1  sticky: at least one fault is logged
- oFltMask  out  MC_SIZE  sticky OR of all qualified channels
- oFirstFltIdx  out  IDX_W  lowest index among the channels that qualified first
- oAckTimeout  out  1  sticky ack-timeout flag (0 without the macro)

## Operation
- FSM states: IDLE, ARMED, REQ, LATCHED.
- IDLE → ARMED when iCpuPwrGd=1 and &iPWRGD_DRAMPWRGD_OK=1 and iSlpS5Id=0.
- ARMED → IDLE when iCpuPwrGd=0 or iSlpS5Id=1. This is a normal power-down, so no log entry is made. iSlpS5Id wins over a simultaneous qualification.
- ARMED → REQ when any channel qualifies. In the same update:
  - oFltMask gets every channel that qualifies on that edge.
  - oFirstFltIdx gets the lowest such index.
  - oFltValid is set to 1.
- REQ → LATCHED on an edge with iFltAck=1. iFltAck is ignored in IDLE and ARMED.
- LATCHED → IDLE on an edge with iSlpS5Id=1. This clears oFltMask, oFltValid, oFirstFltIdx and oAckTimeout.
- Per-channel filter:
  - Counter width $clog2(FILT_CYCLES+1).
  - Increments on each edge where the fault input is 1; resets to 0 on any edge where it is 0.
  - Saturates at FILT_CYCLES.
  - The channel qualifies on the edge where the counter reaches FILT_CYCLES.
  - All counters are held at 0 in IDLE.
- In REQ and LATCHED, filters keep running. Later qualifications OR into oFltMask; oFirstFltIdx does not change.
- Reset values: oFltPwrDwnReq=0, oFltValid=0, oFltMask=0, oFirstFltIdx=0, oAckTimeout=0, FSM=IDLE, counters=0.

## Timing
- All outputs are registered and reflect the state after each edge. There is no combinational input-to-output path.
- Fault asserted and sampled at edges 1..FILT_CYCLES → oFltPwrDwnReq, oFltValid and oFltMask are high after edge FILT_CYCLES. Latency is FILT_CYCLES clocks from the first sampling edge.
- iFltAck sampled high → oFltPwrDwnReq low after that same edge. Ack is a single-cycle pulse or a level; both are accepted.
- Ack and a new qualification on the same edge: go to LATCHED and OR the new bit into the mask.
- Asynchronous reset at any point, including mid-REQ: all outputs go to reset values immediately and the request is dropped.

## Configuration
- DDR5_FLT_ACK_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in REQ.
  - After TIMEOUT_CYCLES edges without ack: oAckTimeout=1 (sticky), oFltPwrDwnReq=0, FSM → LATCHED.
  - Ack on the timeout edge takes priority (no timeout flagged).
- Undefined: no timeout counter, REQ waits indefinitely, oAckTimeout tied 0.

## Structure
- Package ddr5_flt_pkg: FSM state enum (2-bit) and the default FILT_CYCLES/TIMEOUT_CYCLES constants.
- Sub-module ddr5_flt_filter: one per channel via generate. It holds the saturating consecutive-sample counter and a one-cycle qualify pulse, and clears while in IDLE.
- The top level holds the FSM, log registers, priority encoder and the optional timeout counter.

## Test plan
- Arm (iCpuPwrGd=1, OK=4'hF), hold iDIMM_MEM_FLT=4'b0100 for 4 clocks → oFltPwrDwnReq=1 after edge 4, oFltMask=4'b0100, oFirstFltIdx=2; pulse iFltAck → req=0 next edge, log retained.
- Glitch: fault on ch0 for 3 clocks, low 1 clock, high 3 clocks → no request, oFltValid=0.
- Simultaneous: ch1 and ch3 qualify on the same edge → mask=4'b1010, oFirstFltIdx=1; ch0 qualifies later in LATCHED → mask=4'b1011, idx still 1.
- Disarm: iCpuPwrGd falls while ch2 counter=3 → IDLE, no request; re-arm → counter restarts from 0. In LATCHED, iSlpS5Id=1 → all log outputs 0.
- Timeout (macro on, TIMEOUT_CYCLES=10): qualify, no ack → after 10 edges oAckTimeout=1, req=0. Ack on edge 10 → oAckTimeout=0. Macro off: req held 1000 clocks.
- Reset asserted mid-REQ → all outputs 0 asynchronously; after release the monitor is in IDLE.
